adc_capture_gate: RTL and testbench
===================================

ADC_CAPTURE_GATE -- requirements
Module: adc_capture_gate

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning ADC beat width (8 signed 16-bit samples; sample k = bits [16k+15:16k]).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of beat and drop counters.
REQ-003 SHALL have port rf_clk  input  1  ADC stream clock; all logic on its rising edge; one clock only.
REQ-004 SHALL have port rf_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports s_axis_tvalid  input  1 / s_axis_tdata  input  DATA_W / s_axis_tready  output  1  RF ADC stream input.
REQ-006 SHALL have ports m_axis_tvalid  output  1 / m_axis_tdata  output  DATA_W / m_axis_tlast  output  1 / m_axis_tready  input  1  gated stream to the ADC data path.
REQ-007 SHALL have ports arm, abort, sw_trig  input  1 each  single-cycle control pulses.
REQ-008 SHALL have ports trig_mode  input  1  (0 software, 1 threshold); threshold  input  16  signed level; cap_beats  input  CNT_W  beats per capture.
REQ-009 SHALL have outputs busy  1, cap_done  1, ovf  1, beat_count  CNT_W, drop_count  CNT_W.

Function
REQ-010 SHALL drive s_axis_tready constant 1; the ADC source is never back-pressured.
REQ-011 SHALL implement states IDLE, ARMED, CAPTURE, DONE; busy = 1 in ARMED or CAPTURE.
REQ-012 Priority per cycle SHALL be abort > arm > trigger/capture progress.
REQ-013 abort in any state SHALL go to IDLE next cycle, clear trigger pending, keep counters and ovf; an already-loaded output beat SHALL remain valid until accepted.
REQ-014 arm in IDLE or DONE SHALL latch cap_beats, clear beat_count, drop_count, ovf, cap_done, trigger pending, and go to ARMED; if latched cap_beats = 0 go directly to DONE with cap_done = 1; arm in ARMED/CAPTURE SHALL be ignored.
REQ-015 In ARMED, trig_mode 0: sw_trig SHALL set a pending flag; first valid beat in the same or a later cycle is the first captured beat.
REQ-016 In ARMED, trig_mode 1: a valid beat SHALL trigger when any of its 8 samples, signed, is strictly greater than threshold; that beat is the first captured beat; sw_trig ignored.
REQ-017 Triggering beat and every valid beat in CAPTURE SHALL be "window beats"; each increments beat_count by 1 whether forwarded or dropped.
REQ-018 Output SHALL be one register stage: window beat loads m_axis_tdata/tvalid on the cycle after it is presented when m_axis_tvalid = 0 or m_axis_tready = 1.
REQ-019 A window beat arriving while m_axis_tvalid = 1 and m_axis_tready = 0 SHALL be dropped, increment drop_count (saturating at all-ones), and set sticky ovf.
REQ-020 The window beat with beat_count reaching latched cap_beats SHALL be loaded with m_axis_tlast = 1 (if not dropped); state goes to DONE and cap_done = 1 on the same edge.
REQ-021 m_axis_tvalid SHALL clear after a cycle with m_axis_tready = 1 and no new load; tdata/tlast SHALL be stable while tvalid = 1 and tready = 0.
REQ-022 beat_count SHALL not exceed latched cap_beats; non-window beats (IDLE, ARMED untriggered, DONE) SHALL be discarded without counting.
REQ-023 cap_done SHALL stay 1 in DONE until next arm or abort.
REQ-024 cap_beats changes after arm SHALL not affect the running capture.

Reset
REQ-025 rf_rst = 1 SHALL asynchronously force state IDLE, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, busy = 0, cap_done = 0, ovf = 0, beat_count = 0, drop_count = 0, pending = 0, latched cap_beats = 0.
REQ-026 Reset release mid-stream SHALL start in IDLE; no beat forwarded until arm and trigger.

Verification
REQ-027 Software capture: cap_beats = 4, arm, sw_trig, continuous valid, tready = 1 -> exactly 4 beats out, 4th tlast = 1, beat_count = 4, cap_done = 1, drop_count = 0.
REQ-028 Threshold: trig_mode 1, threshold = 1000, beats with max sample 999 then sample 1001 -> first output beat is the one containing 1001; 999 beat never output; threshold = -1 with all samples 0 triggers immediately.
REQ-029 Back-pressure: cap_beats = 8, tready = 0 for 3 cycles mid-capture -> drop_count = 3, ovf = 1, beat_count = 8, 5 beats delivered, held beat stable during stall.
REQ-030 Abort: cap_beats = 100, abort after 10 beats -> IDLE, busy = 0, cap_done = 0, beat_count = 10, no further beats; re-arm clears counters.
REQ-031 Edge cases: arm with cap_beats = 0 -> DONE, cap_done = 1, no output; arm and abort same cycle -> IDLE; rf_rst asserted mid-capture -> all outputs zero immediately, asynchronously.

Source files
------------

// File: rtl/adc_capture_gate.sv
// Capture gate between the RF ADC stream and the ADC data path: arms, waits
// for a software or threshold trigger, then forwards a fixed number of beats.
module adc_capture_gate #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic                rf_clk,
  input  logic                rf_rst,
  input  logic                s_axis_tvalid,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  output logic                s_axis_tready,
  output logic                m_axis_tvalid,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  input  logic                arm,
  input  logic                abort,
  input  logic                sw_trig,
  input  logic                trig_mode,
  input  logic signed [15:0]  threshold,
  input  logic [CNT_W-1:0]    cap_beats,
  output logic                busy,
  output logic                cap_done,
  output logic                ovf,
  output logic [CNT_W-1:0]    beat_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic [1:0]          fsm_state
);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1;
  // the input side is always ready, the output side holds data while stalled.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int N_SAMP = DATA_W / 16;

  state_t             state;
  logic               pending;
  logic [CNT_W-1:0]   cap_lat;
  logic               thr_hit;
  logic               trig_now;
  logic               window;
  logic               out_ready;
  logic               last_beat;
  logic [CNT_W-1:0]   beat_next;

  always_comb begin
    thr_hit = 1'b0;
    for (int k = 0; k < N_SAMP; k++) begin
      if ($signed(s_axis_tdata[16*k +: 16]) > threshold) thr_hit = 1'b1;
    end
  end

  assign trig_now      = trig_mode ? thr_hit : (pending | sw_trig);
  assign window        = s_axis_tvalid &&
                         ((state == CAPTURE) || ((state == ARMED) && trig_now));
  assign out_ready     = !m_axis_tvalid || m_axis_tready;
  assign beat_next     = beat_count + CNT_W'(1);
  assign last_beat     = (beat_next == cap_lat);
  assign s_axis_tready = 1'b1;
  assign busy          = (state == ARMED) || (state == CAPTURE);
  assign fsm_state     = state;

  always_ff @(posedge rf_clk or posedge rf_rst) begin
    if (rf_rst) begin
      state         <= IDLE;
      pending       <= 1'b0;
      cap_lat       <= '0;
      cap_done      <= 1'b0;
      ovf           <= 1'b0;
      beat_count    <= '0;
      drop_count    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      // An accepted output beat drains unless a new window beat reloads below.
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (abort) begin
        state    <= IDLE;
        pending  <= 1'b0;
        cap_done <= 1'b0;
      end else if (arm && ((state == IDLE) || (state == DONE))) begin
        cap_lat    <= cap_beats;
        beat_count <= '0;
        drop_count <= '0;
        ovf        <= 1'b0;
        pending    <= 1'b0;
        if (cap_beats == '0) begin
          state    <= DONE;
          cap_done <= 1'b1;
        end else begin
          state    <= ARMED;
          cap_done <= 1'b0;
        end
      end else begin
        if ((state == ARMED) && !trig_mode && sw_trig && !window) pending <= 1'b1;
        if (window) begin
          beat_count <= beat_next;
          pending    <= 1'b0;
          if (out_ready) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_beat;
          end else begin
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
            ovf <= 1'b1;
          end
          if (last_beat) begin
            state    <= DONE;
            cap_done <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_gate.sv
// Directed bench for adc_capture_gate: software/threshold triggering,
// back-pressure drops, abort, zero-length capture and asynchronous reset.
module tb_adc_capture_gate;

  localparam int DATA_W = 128;
  localparam int CNT_W  = 32;

  logic                clk = 1'b0;
  logic                rf_rst;
  logic                s_axis_tvalid;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic                s_axis_tready;
  logic                m_axis_tvalid;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic                m_axis_tlast;
  logic                m_axis_tready;
  logic                arm, abort, sw_trig, trig_mode;
  logic signed [15:0]  threshold;
  logic [CNT_W-1:0]    cap_beats;
  logic                busy, cap_done, ovf;
  logic [CNT_W-1:0]    beat_count, drop_count;
  logic [1:0]          fsm_state;

  int total = 0;
  int bad   = 0;

  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] got_q[$];

  adc_capture_gate #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .rf_clk(clk), .rf_rst(rf_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .arm(arm), .abort(abort), .sw_trig(sw_trig), .trig_mode(trig_mode),
    .threshold(threshold), .cap_beats(cap_beats),
    .busy(busy), .cap_done(cap_done), .ovf(ovf),
    .beat_count(beat_count), .drop_count(drop_count), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // output monitor: a transfer is pending at the next rising edge
  always @(negedge clk) begin
    if (!rf_rst && m_axis_tvalid && m_axis_tready)
      got_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  function automatic logic [DATA_W-1:0] beat(input int id);
    logic [DATA_W-1:0] b;
    b = '0;
    b[15:0] = id[15:0];
    b[DATA_W-1 -: 16] = 16'h0100 | id[15:0];
    return b;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    tick();
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rf_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rf_rst = 1'b0;
    tick();
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%0b exp=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== '0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", m_axis_tdata); end
    total++; if ({busy, cap_done, ovf, m_axis_tlast} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {busy, cap_done, ovf, m_axis_tlast}); end
    total++; if (beat_count !== '0 || drop_count !== '0) begin bad++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", beat_count, drop_count); end
    total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", fsm_state); end
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_sready got=%0b exp=1", s_axis_tready); end
  endtask

  task automatic test_sw_capture();
    got_q.delete(); exp_q.delete();
    trig_mode = 1'b0; m_axis_tready = 1'b1; cap_beats = 4;
    send_beat(beat(16'h0a1));
    send_beat(beat(16'h0a2));
    s_axis_tvalid = 1'b0;
    pulse_arm();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sw_busy got=%0b exp=1", busy); end
    cap_beats = 2;
    sw_trig = 1'b1; tick(); sw_trig = 1'b0;
    for (int i = 1; i <= 6; i++) send_beat(beat(i));
    idle(3);
    for (int i = 1; i <= 4; i++) exp_q.push_back({(i == 4), beat(i)});
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sw_out_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL sw_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (beat_count !== 4) begin bad++; $display("FAIL sw_beat_count got=%0d exp=4", beat_count); end
    total++; if (cap_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL sw_done got=%0b/%0b exp=1/0", cap_done, busy); end
    total++; if (drop_count !== 0 || ovf !== 1'b0) begin bad++; $display("FAIL sw_drop got=%0d/%0b exp=0/0", drop_count, ovf); end
  endtask

  task automatic test_threshold();
    logic [DATA_W-1:0] ba, bb, bz;
    got_q.delete(); exp_q.delete();
    ba = '0; ba[15:0] = 16'hfffb; ba[63:48] = 16'd999;
    bb = '0; bb[95:80] = 16'd1001;
    bz = '0;
    trig_mode = 1'b1; threshold = 16'sd1000; cap_beats = 2;
    pulse_arm();
    sw_trig = 1'b1; send_beat(ba); sw_trig = 1'b0;
    total++; if (fsm_state !== 2'd1 || beat_count !== 0) begin bad++; $display("FAIL thr_not_trig got=%0d/%0d exp=1/0", fsm_state, beat_count); end
    send_beat(bb);
    send_beat(beat(3));
    send_beat(beat(4));
    idle(3);
    exp_q.push_back({1'b0, bb});
    exp_q.push_back({1'b1, beat(3)});
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL thr_out_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL thr_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (beat_count !== 2 || cap_done !== 1'b1) begin bad++; $display("FAIL thr_done got=%0d/%0b exp=2/1", beat_count, cap_done); end
    got_q.delete(); exp_q.delete();
    threshold = -16'sd1; cap_beats = 1;
    pulse_arm();
    send_beat(bz);
    send_beat(beat(5));
    idle(3);
    exp_q.push_back({1'b1, bz});
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL thr_neg_count got=%0d exp=1", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL thr_neg_beat got=%h exp=%h", got_q[i], exp_q[i]); end
    end
    total++; if (beat_count !== 1 || cap_done !== 1'b1) begin bad++; $display("FAIL thr_neg_done got=%0d/%0b exp=1/1", beat_count, cap_done); end
    trig_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete();
    trig_mode = 1'b0; cap_beats = 8; m_axis_tready = 1'b1;
    pulse_arm();
    for (int i = 1; i <= 8; i++) begin
      sw_trig = (i == 1);
      m_axis_tready = !(i >= 3 && i <= 5);
      send_beat(beat(i));
      if (i >= 2 && i <= 4) begin
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== beat(2)) begin
          bad++; $display("FAIL bp_hold_c%0d got=%0b/%h exp=1/%h", i + 1, m_axis_tvalid, m_axis_tdata, beat(2));
        end
      end
    end
    sw_trig = 1'b0; m_axis_tready = 1'b1;
    idle(3);
    exp_q.push_back({1'b0, beat(1)});
    exp_q.push_back({1'b0, beat(2)});
    exp_q.push_back({1'b0, beat(6)});
    exp_q.push_back({1'b0, beat(7)});
    exp_q.push_back({1'b1, beat(8)});
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_out_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (drop_count !== 3 || ovf !== 1'b1) begin bad++; $display("FAIL bp_drop got=%0d/%0b exp=3/1", drop_count, ovf); end
    total++; if (beat_count !== 8 || cap_done !== 1'b1) begin bad++; $display("FAIL bp_done got=%0d/%0b exp=8/1", beat_count, cap_done); end
  endtask

  task automatic test_abort();
    got_q.delete(); exp_q.delete();
    cap_beats = 100; m_axis_tready = 1'b1;
    pulse_arm();
    total++; if (ovf !== 1'b0 || drop_count !== 0) begin bad++; $display("FAIL ab_arm_clear got=%0b/%0d exp=0/0", ovf, drop_count); end
    for (int i = 1; i <= 10; i++) begin
      sw_trig = (i == 1);
      send_beat(beat(i));
      exp_q.push_back({1'b0, beat(i)});
    end
    sw_trig = 1'b0;
    abort = 1'b1; send_beat(beat(11)); abort = 1'b0;
    for (int i = 12; i <= 14; i++) send_beat(beat(i));
    idle(3);
    total++; if (fsm_state !== 2'd0 || busy !== 1'b0 || cap_done !== 1'b0) begin bad++; $display("FAIL ab_idle got=%0d/%0b/%0b exp=0/0/0", fsm_state, busy, cap_done); end
    total++; if (beat_count !== 10) begin bad++; $display("FAIL ab_beat_count got=%0d exp=10", beat_count); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ab_out_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ab_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    cap_beats = 3;
    pulse_arm();
    total++; if (beat_count !== 0 || busy !== 1'b1) begin bad++; $display("FAIL ab_rearm got=%0d/%0b exp=0/1", beat_count, busy); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_edge();
    got_q.delete(); exp_q.delete();
    cap_beats = 0;
    pulse_arm();
    total++; if (fsm_state !== 2'd3 || cap_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done got=%0d/%0b/%0b exp=3/1/0", fsm_state, cap_done, busy); end
    sw_trig = 1'b1; send_beat(beat(1)); sw_trig = 1'b0;
    send_beat(beat(2));
    idle(2);
    total++; if (got_q.size() != 0 || beat_count !== 0) begin bad++; $display("FAIL zero_no_out got=%0d/%0d exp=0/0", got_q.size(), beat_count); end
    cap_beats = 5; arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    total++; if (fsm_state !== 2'd0 || cap_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arm_abort got=%0d/%0b/%0b exp=0/0/0", fsm_state, cap_done, busy); end
    // asynchronous reset in the middle of a capture
    got_q.delete(); exp_q.delete();
    cap_beats = 10;
    pulse_arm();
    sw_trig = 1'b1; send_beat(beat(1)); sw_trig = 1'b0;
    send_beat(beat(2));
    send_beat(beat(3));
    total++; if (beat_count !== 3 || m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL pre_rst got=%0d/%0b exp=3/1", beat_count, m_axis_tvalid); end
    #1 rf_rst = 1'b1;
    #1;
    total++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin bad++; $display("FAIL async_rst_out got=%0b/%h/%0b exp=0/0/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    total++; if (beat_count !== 0 || drop_count !== 0 || {busy, cap_done, ovf} !== 3'b0 || fsm_state !== 2'd0) begin
      bad++; $display("FAIL async_rst_state got=%0d/%0d/%b/%0d exp=0/0/000/0", beat_count, drop_count, {busy, cap_done, ovf}, fsm_state);
    end
    @(posedge clk); #1 rf_rst = 1'b0;
    sw_trig = 1'b1; send_beat(beat(4)); sw_trig = 1'b0;
    send_beat(beat(5));
    send_beat(beat(6));
    idle(3);
    exp_q.push_back({1'b0, beat(1)});
    exp_q.push_back({1'b0, beat(2)});
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_out_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (beat_count !== 0 || fsm_state !== 2'd0) begin bad++; $display("FAIL post_rst_idle got=%0d/%0d exp=0/0", beat_count, fsm_state); end
  endtask

  initial begin
    rf_rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    arm = 1'b0; abort = 1'b0; sw_trig = 1'b0; trig_mode = 1'b0;
    threshold = 16'sd0; cap_beats = '0;
    test_reset();
    test_sw_capture();
    test_threshold();
    test_back_to_back();
    test_abort();
    test_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
